// File: rtl/line_cache_ctrl.sv
// Line-cache sequencer: copies prev/cur/next GBA lines from a 4-slot line RAM into the idle
// bank of a double-buffered cache. Define NEIGHBOUR_ROWS_EN to fetch all three rows (else cur only).
module line_cache_ctrl #(
  parameter int LINE_PIXELS = 240,
  parameter int LINE_COUNT  = 160
) (
  input  logic        pxlClk,
  input  logic        rst,
  input  logic        newFrame,
  input  logic        wrLineDone,
  input  logic        nextLine,
  input  logic        cacheUpdate,
  output logic [9:0]  ramAddr,
  output logic        ramRe,
  input  logic [23:0] ramData,
  output logic        cacheWe,
  output logic [1:0]  cacheRow,
  output logic [7:0]  cacheAddr,
  output logic [23:0] cacheData,
  output logic        bankSel,
  output logic        busy,
  output logic [7:0]  curLine,
  output logic        underrun
);

  localparam logic [7:0] LAST_PXL  = 8'(LINE_PIXELS - 1);
  localparam logic [7:0] LAST_LINE = 8'(LINE_COUNT - 1);
  localparam logic [7:0] LINE_CNT  = 8'(LINE_COUNT);
`ifdef NEIGHBOUR_ROWS_EN
  localparam logic [1:0] FIRST_ROW = 2'd0;
  localparam logic [1:0] LAST_ROW  = 2'd2;
`else
  localparam logic [1:0] FIRST_ROW = 2'd1;
  localparam logic [1:0] LAST_ROW  = 2'd1;
`endif

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_SWAP} state_t;

  state_t      state_q, state_d;
  logic [7:0]  wr_cnt_q, wr_cnt_d;
  logic [7:0]  cur_line_q, cur_line_d;
  logic        pend_q, pend_d;
  logic        underrun_q, underrun_d;
  logic        bank_q, bank_d;
  logic        busy_q, busy_d;
  logic [1:0]  slot0_q, slot0_d, slot1_q, slot1_d, slot2_q, slot2_d;
  logic [1:0]  row_q, row_d;
  logic [7:0]  pxl_q, pxl_d;
  logic        re_q, re_d;
  logic [9:0]  addr_q, addr_d;
  logic        re1_q, we_q;
  logic [1:0]  row1_q, crow_q;
  logic [7:0]  pxl1_q, caddr_q;
  logic [23:0] cdata_q;

  logic [7:0]  cur_adv_s;
  logic [1:0]  map0_s, map1_s, map2_s;
  logic        fetch_bad_s;
  logic        last_read_s;

  function automatic logic [7:0] line_inc(input logic [7:0] line);
    logic [7:0] nxt;
    nxt = (line >= LAST_LINE) ? LAST_LINE : line + 8'd1;
    return nxt;
  endfunction

  // Neighbour rows clamp to the frame edges, replicating cur there
  function automatic logic [7:0] row_line(input logic [7:0] cur, input logic [1:0] row);
    logic [7:0] tgt;
    case (row)
      2'd0:    tgt = (cur == 8'd0) ? cur : cur - 8'd1;
      2'd2:    tgt = (cur >= LAST_LINE) ? cur : cur + 8'd1;
      default: tgt = cur;
    endcase
    return tgt;
  endfunction

  function automatic logic [1:0] row_slot(input logic [7:0] cur, input logic [1:0] row,
                                          input logic [7:0] wr_cnt);
    logic [7:0] tgt;
    tgt = row_line(cur, row);
    return (tgt >= wr_cnt) ? cur[1:0] : tgt[1:0];
  endfunction

  function automatic logic row_bad(input logic [7:0] cur, input logic [1:0] row,
                                   input logic [7:0] wr_cnt);
    return (cur >= wr_cnt) || (row_line(cur, row) >= wr_cnt);
  endfunction

  function automatic logic [1:0] slot_pick(input logic [1:0] row, input logic [1:0] s0,
                                           input logic [1:0] s1, input logic [1:0] s2);
    logic [1:0] sel;
    case (row)
      2'd0:    sel = s0;
      2'd2:    sel = s2;
      default: sel = s1;
    endcase
    return sel;
  endfunction

  // Slot mapping for a fetch that would start this cycle (same-cycle advance included)
  always_comb begin
    cur_adv_s   = nextLine ? line_inc(cur_line_q) : cur_line_q;
    map0_s      = row_slot(cur_adv_s, 2'd0, wr_cnt_q);
    map1_s      = row_slot(cur_adv_s, 2'd1, wr_cnt_q);
    map2_s      = row_slot(cur_adv_s, 2'd2, wr_cnt_q);
`ifdef NEIGHBOUR_ROWS_EN
    fetch_bad_s = row_bad(cur_adv_s, 2'd0, wr_cnt_q) | row_bad(cur_adv_s, 2'd1, wr_cnt_q) |
                  row_bad(cur_adv_s, 2'd2, wr_cnt_q);
`else
    fetch_bad_s = row_bad(cur_adv_s, 2'd1, wr_cnt_q);
`endif
    last_read_s = (pxl_q == LAST_PXL) && (row_q == LAST_ROW);
  end

  // State register
  always_ff @(posedge pxlClk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (newFrame) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  state_d = cacheUpdate ? S_FETCH : S_IDLE;
        S_FETCH: state_d = last_read_s ? S_DRAIN : S_FETCH;
        S_DRAIN: state_d = re1_q ? S_DRAIN : S_SWAP;
        S_SWAP:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output and datapath next-state logic
  always_comb begin
    cur_line_d = cur_line_q;
    pend_d     = pend_q;
    underrun_d = underrun_q;
    bank_d     = bank_q;
    slot0_d    = slot0_q;
    slot1_d    = slot1_q;
    slot2_d    = slot2_q;
    row_d      = row_q;
    pxl_d      = pxl_q;
    re_d       = 1'b0;
    addr_d     = addr_q;
    busy_d     = (state_d != S_IDLE);
    if (newFrame) begin
      wr_cnt_d = wrLineDone ? 8'd1 : 8'd0;
    end else if (wrLineDone && (wr_cnt_q < LINE_CNT)) begin
      wr_cnt_d = wr_cnt_q + 8'd1;
    end else begin
      wr_cnt_d = wr_cnt_q;
    end
    if (newFrame) begin
      cur_line_d = 8'd0;
      pend_d     = 1'b0;
      underrun_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cur_line_d = cur_adv_s;
          if (cacheUpdate) begin
            slot0_d    = map0_s;
            slot1_d    = map1_s;
            slot2_d    = map2_s;
            underrun_d = underrun_q | fetch_bad_s;
            row_d      = FIRST_ROW;
            pxl_d      = 8'd0;
            re_d       = 1'b1;
            addr_d     = {slot_pick(FIRST_ROW, map0_s, map1_s, map2_s), 8'd0};
          end else begin
            re_d = 1'b0;
          end
        end
        S_FETCH: begin
          pend_d     = pend_q | nextLine;
          underrun_d = underrun_q | cacheUpdate;
          if (last_read_s) begin
            re_d = 1'b0;
          end else begin
            re_d = 1'b1;
            if (row_q == LAST_ROW) begin
              row_d = FIRST_ROW;
              pxl_d = pxl_q + 8'd1;
            end else begin
              row_d = row_q + 2'd1;
              pxl_d = pxl_q;
            end
            addr_d = {slot_pick(row_d, slot0_q, slot1_q, slot2_q), pxl_d};
          end
        end
        S_DRAIN: begin
          pend_d     = pend_q | nextLine;
          underrun_d = underrun_q | cacheUpdate;
          bank_d     = re1_q ? bank_q : ~bank_q;
        end
        S_SWAP: begin
          underrun_d = underrun_q | cacheUpdate;
          cur_line_d = (pend_q | nextLine) ? line_inc(cur_line_q) : cur_line_q;
          pend_d     = 1'b0;
        end
        default: begin
          cur_line_d = cur_line_q;
        end
      endcase
    end
  end

  // Control and read-issue registers
  always_ff @(posedge pxlClk or posedge rst) begin
    if (rst) begin
      wr_cnt_q   <= 8'd0;
      cur_line_q <= 8'd0;
      pend_q     <= 1'b0;
      underrun_q <= 1'b0;
      bank_q     <= 1'b0;
      busy_q     <= 1'b0;
      slot0_q    <= 2'd0;
      slot1_q    <= 2'd0;
      slot2_q    <= 2'd0;
      row_q      <= 2'd0;
      pxl_q      <= 8'd0;
      re_q       <= 1'b0;
      addr_q     <= 10'd0;
    end else begin
      wr_cnt_q   <= wr_cnt_d;
      cur_line_q <= cur_line_d;
      pend_q     <= pend_d;
      underrun_q <= underrun_d;
      bank_q     <= bank_d;
      busy_q     <= busy_d;
      slot0_q    <= slot0_d;
      slot1_q    <= slot1_d;
      slot2_q    <= slot2_d;
      row_q      <= row_d;
      pxl_q      <= pxl_d;
      re_q       <= re_d;
      addr_q     <= addr_d;
    end
  end

  // Write pipeline: RAM latency stage, then registered cache write; newFrame kills in-flight writes
  always_ff @(posedge pxlClk or posedge rst) begin
    if (rst) begin
      re1_q   <= 1'b0;
      row1_q  <= 2'd0;
      pxl1_q  <= 8'd0;
      we_q    <= 1'b0;
      crow_q  <= 2'd0;
      caddr_q <= 8'd0;
      cdata_q <= 24'd0;
    end else if (newFrame) begin
      re1_q <= 1'b0;
      we_q  <= 1'b0;
    end else begin
      re1_q   <= re_q;
      row1_q  <= row_q;
      pxl1_q  <= pxl_q;
      we_q    <= re1_q;
      crow_q  <= row1_q;
      caddr_q <= pxl1_q;
      cdata_q <= re1_q ? ramData : cdata_q;
    end
  end

  assign ramAddr   = addr_q;
  assign ramRe     = re_q;
  assign cacheWe   = we_q;
  assign cacheRow  = crow_q;
  assign cacheAddr = caddr_q;
  assign cacheData = cdata_q;
  assign bankSel   = bank_q;
  assign busy      = busy_q;
  assign curLine   = cur_line_q;
  assign underrun  = underrun_q;

endmodule

// File: tb/tb_line_cache_ctrl.sv
// Bench for line_cache_ctrl: a line-level reference model predicts every cache write into a
// queue; a negedge monitor pops and compares each write the DUT presents.
module tb_line_cache_ctrl;
  localparam int LP = 240;
  localparam int LC = 160;
`ifdef NEIGHBOUR_ROWS_EN
  localparam int NROWS    = 3;
  localparam int FIRST    = 0;
  localparam int ABORT_AT = 300;
`else
  localparam int NROWS    = 1;
  localparam int FIRST    = 1;
  localparam int ABORT_AT = 150;
`endif
  localparam int NREADS = NROWS * LP;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        newFrame = 1'b0, wrLineDone = 1'b0, nextLine = 1'b0, cacheUpdate = 1'b0;
  logic [9:0]  ramAddr;
  logic        ramRe;
  logic [23:0] ramData = 24'd0;
  logic        cacheWe;
  logic [1:0]  cacheRow;
  logic [7:0]  cacheAddr;
  logic [23:0] cacheData;
  logic        bankSel, busy, underrun;
  logic [7:0]  curLine;

  typedef struct {
    int          cyc;
    int          row;
    int          pxl;
    logic [23:0] data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  logic [23:0] mem [4][256];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          m_wr = 0, m_cur = 0, m_pend = 0, m_unr = 0, m_bank = 0;

  line_cache_ctrl #(.LINE_PIXELS(LP), .LINE_COUNT(LC)) dut (
    .pxlClk(clk), .rst(rst), .newFrame(newFrame), .wrLineDone(wrLineDone),
    .nextLine(nextLine), .cacheUpdate(cacheUpdate), .ramAddr(ramAddr), .ramRe(ramRe),
    .ramData(ramData), .cacheWe(cacheWe), .cacheRow(cacheRow), .cacheAddr(cacheAddr),
    .cacheData(cacheData), .bankSel(bankSel), .busy(busy), .curLine(curLine),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Line RAM with one cycle of read latency
  always @(posedge clk) begin
    if (ramRe) ramData <= mem[ramAddr[9:8]][ramAddr[7:0]];
  end

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, wanted %0d", name, got, want);
    end
  endtask

  // Monitor: every cache write must match the head of the expectation queue
  always @(negedge clk) begin
    if (!rst && cacheWe === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got row %0d addr %0d at cycle %0d, wanted no write",
                 cacheRow, cacheAddr, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.cyc != cyc || mon_e.row != int'(cacheRow) || mon_e.pxl != int'(cacheAddr) ||
            mon_e.data !== cacheData) begin
          errors++;
          $display("FAIL cache_write: got cyc %0d row %0d addr %0d data %06h, wanted cyc %0d row %0d addr %0d data %06h",
                   cyc, cacheRow, cacheAddr, cacheData, mon_e.cyc, mon_e.row, mon_e.pxl, mon_e.data);
        end
      end
    end
  end

  function automatic int inc_line(input int l);
    return (l >= LC - 1) ? LC - 1 : l + 1;
  endfunction

  // One idle cycle with the given pulses, reference model updated afterwards
  task automatic idle_cycle(input bit nl, input bit wd, input bit nf);
    nextLine = nl; wrLineDone = wd; newFrame = nf;
    @(posedge clk); #1;
    nextLine = 1'b0; wrLineDone = 1'b0; newFrame = 1'b0;
    if (nf) begin
      m_cur = 0; m_pend = 0; m_unr = 0; m_wr = wd ? 1 : 0;
    end else begin
      if (wd && m_wr < LC) m_wr++;
      if (nl) m_cur = inc_line(m_cur);
    end
  endtask

  // Full fetch; nl_at/cu_at/abort_at (0 = unused) inject pulses during the given cycle
  task automatic run_fetch(input bit same_nl, input int nl_at, input int cu_at, input int abort_at);
    int  slot [3];
    int  l, e_base, idx, old_bank;
    bit  bad;
    wr_t w;
    if (same_nl) m_cur = inc_line(m_cur);
    bad = 1'b0;
    slot[0] = 0; slot[1] = 0; slot[2] = 0;
    for (int r = FIRST; r < FIRST + NROWS; r++) begin
      l = m_cur + r - 1;
      if (l < 0) l = 0;
      if (l > LC - 1) l = LC - 1;
      if (l >= m_wr) begin
        l = m_cur;
        bad = 1'b1;
      end
      slot[r] = l % 4;
    end
    if (m_cur >= m_wr) bad = 1'b1;
    if (bad) m_unr = 1;
    old_bank = m_bank;
    e_base = cyc + 1;
    idx = 0;
    for (int p = 0; p < LP; p++) begin
      for (int r = FIRST; r < FIRST + NROWS; r++) begin
        w.cyc = e_base + idx + 2; w.row = r; w.pxl = p; w.data = mem[slot[r]][p];
        exp_q.push_back(w);
        idx++;
      end
    end
    cacheUpdate = 1'b1; nextLine = same_nl;
    for (int c = 1; c <= NREADS + 4; c++) begin
      @(posedge clk); #1;
      cacheUpdate = 1'b0; nextLine = 1'b0; newFrame = 1'b0;
      if (abort_at > 0 && c == abort_at + 1) begin
        check("abort_busy", int'(busy), 0);
        check("abort_ramRe", int'(ramRe), 0);
        check("abort_cacheWe", int'(cacheWe), 0);
        check("abort_bankSel", int'(bankSel), old_bank);
        check("abort_curLine", int'(curLine), 0);
        check("abort_underrun", int'(underrun), 0);
        exp_q.delete();
        break;
      end
      if (c == 1) begin
        check("start_busy", int'(busy), 1);
        check("start_ramRe", int'(ramRe), 1);
        check("start_curLine", int'(curLine), m_cur);
        check("start_underrun", int'(underrun), m_unr);
      end
      if (c == NREADS) check("last_ramRe", int'(ramRe), 1);
      if (c == NREADS + 1) begin
        check("end_ramRe", int'(ramRe), 0);
        check("drain_busy", int'(busy), 1);
      end
      if (c == NREADS + 2) check("pre_swap_bank", int'(bankSel), old_bank);
      if (c == NREADS + 3) begin
        check("swap_bank", int'(bankSel), 1 - old_bank);
        check("swap_busy", int'(busy), 1);
        m_bank = 1 - old_bank;
        if (m_pend != 0) m_cur = inc_line(m_cur);
        m_pend = 0;
      end
      if (c == NREADS + 4) begin
        check("idle_busy", int'(busy), 0);
        check("idle_curLine", int'(curLine), m_cur);
        check("idle_underrun", int'(underrun), m_unr);
        check("queue_drained", exp_q.size(), 0);
      end
      if (cu_at > 0 && c == cu_at + 1) check("busy_update_underrun", int'(underrun), 1);
      if (nl_at > 0 && c == nl_at) begin
        nextLine = 1'b1; m_pend = 1;
      end
      if (cu_at > 0 && c == cu_at) begin
        cacheUpdate = 1'b1; m_unr = 1;
      end
      if (abort_at > 0 && c == abort_at) begin
        newFrame = 1'b1;
        m_cur = 0; m_pend = 0; m_unr = 0; m_wr = 0;
      end
    end
  endtask

  initial begin
    int n;
    bit b1, b2;
    for (int s = 0; s < 4; s++)
      for (int p = 0; p < 256; p++) mem[s][p] = 24'($urandom);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_known", int'($isunknown({ramAddr, ramRe, cacheWe, cacheRow, cacheAddr, cacheData,
                                          bankSel, busy, curLine, underrun})), 0);
    check("reset_ramRe", int'(ramRe), 0);
    check("reset_cacheWe", int'(cacheWe), 0);
    check("reset_ramAddr", int'(ramAddr), 0);
    check("reset_cacheData", int'(cacheData), 0);
    check("reset_bankSel", int'(bankSel), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_curLine", int'(curLine), 0);
    check("reset_underrun", int'(underrun), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic fetch at the top edge
    repeat (3) idle_cycle(1'b0, 1'b1, 1'b0);
    run_fetch(1'b0, 0, 0, 0);
    check("basic_bankSel", int'(bankSel), 1);
    check("basic_underrun", int'(underrun), 0);

    // Line 2 with only three lines written
    idle_cycle(1'b1, 1'b0, 1'b0);
    idle_cycle(1'b1, 1'b0, 1'b0);
    check("line2_curLine", int'(curLine), 2);
    run_fetch(1'b0, 0, 0, 0);
`ifdef NEIGHBOUR_ROWS_EN
    check("line2_underrun", int'(underrun), 1);
`else
    check("line2_underrun", int'(underrun), 0);
`endif
    repeat (5) idle_cycle(1'b0, 1'b0, 1'b0);
    check("underrun_sticky", int'(underrun), m_unr);
    idle_cycle(1'b0, 1'b0, 1'b1);
    check("nf_underrun", int'(underrun), 0);
    check("nf_curLine", int'(curLine), 0);

    // Bottom edge
    repeat (LC + 4) idle_cycle(1'b0, 1'b1, 1'b0);
    repeat (LC - 1) idle_cycle(1'b1, 1'b0, 1'b0);
    check("bottom_curLine", int'(curLine), LC - 1);
    idle_cycle(1'b1, 1'b0, 1'b0);
    check("bottom_saturate", int'(curLine), LC - 1);
    run_fetch(1'b0, 0, 0, 0);
    check("bottom_underrun", int'(underrun), 0);

    // Same-cycle advance plus a pending advance at cycle 100
    idle_cycle(1'b0, 1'b0, 1'b1);
    repeat (8) idle_cycle(1'b0, 1'b1, 1'b0);
    repeat (4) idle_cycle(1'b1, 1'b0, 1'b0);
    run_fetch(1'b1, 100, 0, 0);
    check("pending_curLine", int'(curLine), 6);

    // Abort mid-fetch; the line counter restarts so the next fetch underruns
    run_fetch(1'b0, 0, 0, ABORT_AT);
    run_fetch(1'b0, 0, 0, 0);
    check("post_abort_underrun", int'(underrun), 1);

    // newFrame together with wrLineDone, then cacheUpdate while busy
    idle_cycle(1'b1, 1'b1, 1'b1);
    check("nf_wd_curLine", int'(curLine), 0);
    idle_cycle(1'b0, 1'b1, 1'b0);
    idle_cycle(1'b0, 1'b1, 1'b0);
    run_fetch(1'b0, 0, 50, 0);

    // Randomized sequences
    for (int it = 0; it < 6; it++) begin
      b1 = ($urandom_range(0, 1) != 0);
      b2 = ($urandom_range(0, 1) != 0);
      if (b1) idle_cycle(1'b0, b2, 1'b1);
      n = int'($urandom_range(0, 5));
      repeat (n) idle_cycle(1'b0, 1'b1, 1'b0);
      n = int'($urandom_range(0, 3));
      repeat (n) idle_cycle(1'b1, 1'b0, 1'b0);
      check("rand_curLine", int'(curLine), m_cur);
      b1 = ($urandom_range(0, 1) != 0);
      n = ($urandom_range(0, 1) != 0) ? int'($urandom_range(2, NREADS)) : 0;
      run_fetch(b1, n, 0, 0);
    end

    repeat (4) @(posedge clk);
    #1;
    check("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
